lane_serializer_8: RTL and testbench

//   Drains up to 8 N-bit vector lanes, one at a time, through the external 8:1 lane mux (mux_8NtoN).

---
 rtl/lane_serializer_8.sv | 114 +++++++++++
 tb/tb_lane_serializer_8.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lane_serializer_8.sv
// lane_serializer_8: walks the lanes flagged in a mask in ascending order.
// For each lane it steers the external 8:1 lane mux, registers the selected
// lane and offers it on a valid/ready stream. A one-cycle done pulse closes
// every drain, including one started with an empty mask.
module lane_serializer_8 #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   lane_mask,
    output logic [2:0]   mux_sel,
    output logic         mux_en,
    input  logic [N-1:0] mux_o,
    output logic [N-1:0] out_data,
    output logic [2:0]   out_lane,
    output logic         out_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] pending;    // lanes still to be emitted in this drain
    logic [7:0] remaining;  // pending once the current lane is retired

    // Index of the lowest set bit; only called with a nonzero mask.
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // mux_sel doubles as the current lane index, so the mux select is
    // always a register and never depends on mux_o.
    assign remaining = pending & ~(8'd1 << mux_sel);

    // Drain FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= 8'd0;
            mux_sel   <= 3'd0;
            mux_en    <= 1'b0;
            out_data  <= '0;
            out_lane  <= 3'd0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere here, so every branch
            // reads the pre-edge values of pending/mux_sel, never updated ones.
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pending <= lane_mask;
                        if (lane_mask != 8'd0) begin
                            mux_sel <= lowest_set(lane_mask);
                            mux_en  <= 1'b1;
                            busy    <= 1'b1;
                            state   <= LOAD;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                LOAD: begin
                    out_data  <= mux_o;
                    out_lane  <= mux_sel;
                    out_last  <= (remaining == 8'd0);
                    out_valid <= 1'b1;
                    mux_en    <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        pending   <= remaining;
                        if (remaining != 8'd0) begin
                            mux_sel <= lowest_set(remaining);
                            mux_en  <= 1'b1;
                            state   <= LOAD;
                        end else begin
                            mux_sel <= 3'd0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lane_serializer_8.sv
// tb_lane_serializer_8: directed scenarios plus randomized drains for
// lane_serializer_8. The expected beat order comes from a queue of the set
// mask bits; timing comes from the 2-cycles-per-lane rule plus stall cycles.
module tb_lane_serializer_8;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   lane_mask;
    logic [2:0]   mux_sel;
    logic         mux_en;
    logic [N-1:0] mux_o;
    logic [N-1:0] out_data;
    logic [2:0]   out_lane;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;

    logic [N-1:0] lanes [8];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Behavioural 8:1 lane mux the serializer drives.
    assign mux_o = mux_en ? lanes[mux_sel] : '0;

    lane_serializer_8 #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lane_mask (lane_mask),
        .mux_sel   (mux_sel),
        .mux_en    (mux_en),
        .mux_o     (mux_o),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mux_sel"}, 64'(mux_sel), 64'd0);
        check({tag, "_mux_en"}, 64'(mux_en), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_out_lane"}, 64'(out_lane), 64'd0);
        check({tag, "_out_last"}, 64'(out_last), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // mode 0: always ready; mode 1: random ready; mode 2: stall the first
    // beat for stall_n cycles then always ready. poke issues a stray start
    // pulse on cycle t+3 that must be ignored.
    task automatic run_drain(input string tag, input logic [7:0] mask, input int mode,
                             input int stall_n, input bit poke);
        int  q[$];
        int  k;
        int  cyc;
        int  stalls      = 0;
        int  stalled     = 0;
        int  en_cnt      = 0;
        int  first_valid = -1;
        bit  got_done    = 1'b0;
        for (int i = 0; i < 8; i++) if (mask[i]) q.push_back(i);
        k = q.size();

        lane_mask = mask;
        start     = 1'b1;
        out_ready = (mode == 0);
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        lane_mask = 8'($urandom);  // changes after acceptance must not matter
        cyc = 1;
        while (!got_done && cyc < 200) begin
            start = 1'b0;
            if (mux_en) begin
                en_cnt++;
                check({tag, "_mux_sel"}, 64'(mux_sel), (q.size() > 0) ? 64'(q[0]) : 64'hdead);
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (q.size() > 0) begin
                    check({tag, "_lane"}, 64'(out_lane), 64'(q[0]));
                    check({tag, "_data"}, 64'(out_data), 64'(lanes[q[0]]));
                    check({tag, "_last"}, 64'(out_last), 64'(q.size() == 1));
                end else begin
                    check({tag, "_extra_beat"}, 64'(out_valid), 64'd0);
                end
            end
            if (done) begin
                got_done = 1'b1;
                check({tag, "_done_cycle"}, 64'(cyc), 64'(2 * k + 1 + stalls));
                check({tag, "_lanes_left"}, 64'(q.size()), 64'd0);
                check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
            end else begin
                check({tag, "_busy"}, 64'(busy), 64'(k != 0));
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = 1'($urandom_range(0, 1));
                    default: begin
                        out_ready = !(out_valid && (k - q.size() == 0) && stalled < stall_n);
                        if (!out_ready && out_valid) stalled++;
                    end
                endcase
                if (out_valid && out_ready) void'(q.pop_front());
                else if (out_valid) stalls++;
                if (poke && cyc == 3) start = 1'b1;
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, "_done_seen"}, 64'(got_done), 64'd1);
        check({tag, "_mux_en_cycles"}, 64'(en_cnt), 64'(k));
        if (k > 0) check({tag, "_first_valid"}, 64'(first_valid), 64'd2);
        start     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle_done"}, 64'(done), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_idle_sel"}, 64'(mux_sel), 64'd0);
    endtask

    initial begin
        logic [7:0] rmask;
        bit         seen;
        rst       = 1'b1;
        start     = 1'b0;
        lane_mask = 8'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) lanes[i] = N'(32'hA0 + i);
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("post_reset");

        // T1: reset held for two cycles while a beat waits in WAIT.
        lane_mask = 8'hFF;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check("t1_reached_wait", 64'(seen), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("t1_rst1");
        @(negedge clk);
        check_quiet("t1_rst2");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet("t1_after");
        end

        // T2: full drain of A0..A7 with out_ready held high.
        run_drain("t2_full", 8'hFF, 0, 0, 1'b0);

        // T3: sparse mask, lanes 1, 4, 7.
        for (int i = 0; i < 8; i++) lanes[i] = $urandom;
        run_drain("t3_sparse", 8'b1001_0010, 0, 0, 1'b0);

        // T4: five cycles of backpressure on the first beat.
        for (int i = 0; i < 8; i++) lanes[i] = $urandom;
        run_drain("t4_backpressure", 8'h03, 2, 5, 1'b0);

        // T5: empty mask, then a stray start pulse during a busy drain.
        run_drain("t5_empty", 8'h00, 0, 0, 1'b0);
        run_drain("t5_ignored_start", 8'hFF, 0, 0, 1'b1);

        // T6: single lane 7.
        for (int i = 0; i < 8; i++) lanes[i] = $urandom;
        run_drain("t6_lane7", 8'h80, 0, 0, 1'b0);

        // Randomized drains with random masks and random backpressure.
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 8; i++) lanes[i] = $urandom;
            rmask = 8'($urandom);
            run_drain("rand", rmask, 1, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
